// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, responder FSM states, bus widths.
// Buses are declared [W-1:0]; EBUS bit i maps to vector bit W-1-i, so EBUS
// bit 0 is the numeric MSB exactly as on the EDP.
package ebus_pkg;

  localparam int EBUS_DW  = 36;  // data word
  localparam int EBUS_CSW = 7;   // controller select
  localparam int EBUS_FW  = 3;   // function code
  localparam int EBUS_PIW = 8;   // PI request lines
  localparam int EBUS_LW  = 3;   // PI level field (low 3 bits of CONO word)

  typedef enum logic [EBUS_FW-1:0] {
    funcCONO   = 3'd0,
    funcCONI   = 3'd1,
    funcDATAO  = 3'd2,
    funcDATAI  = 3'd3,
    funcPISERV = 3'd4
  } tEBUSfunc;

  typedef enum logic [2:0] {
    rspIDLE,
    rspSETTLE,
    rspWXFER,
    rspRXFER,
    rspHOLD
  } tEBUSrspState;

  // CONO/CONI/DATAO/DATAI are addressed by controller select
  function automatic logic func_is_dev(input logic [EBUS_FW-1:0] f);
    return f <= 3'd3;
  endfunction

  // write functions capture bus data, the rest drive it
  function automatic logic func_is_write(input tEBUSfunc f);
    return (f == funcCONO) || (f == funcDATAO);
  endfunction

endpackage

// File: rtl/ebus_pi_gen.sv
// PI request generator: decodes the CONO level into a one-hot request line and
// suppresses the request after it has been served until the device drops and
// re-raises dev_pi_req.
module ebus_pi_gen
  import ebus_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [EBUS_LW-1:0]  level,       // 0 disables
  input  logic                dev_pi_req,
  input  logic                serve_done,  // PISERV leaving HOLD
  output logic [EBUS_PIW-1:0] ebus_pi      // EBUS line L = bit 7-L
);

  logic blocked;

  // A served request stays blocked while the device keeps it high; any clock
  // with dev_pi_req low re-arms, so only a fresh rise interrupts again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           blocked <= 1'b0;
    else if (!dev_pi_req) blocked <= 1'b0;
    else if (serve_done)  blocked <= 1'b1;
  end

  // One-hot level decode onto the PI lines
  always_comb begin
    ebus_pi = '0;
    if (dev_pi_req && !blocked && (level != '0))
      ebus_pi[3'd7 - level] = 1'b1;
  end

endmodule

// File: rtl/ebus_responder.sv
// Device-side EBUS endpoint: decodes select/function on DEMAND, waits for the
// bus to settle, then captures (CONO/DATAO) or drives (CONI/DATAI/PISERV) data
// and answers with XFER until DEMAND falls.
module ebus_responder
  import ebus_pkg::*;
#(
  parameter logic [EBUS_CSW-1:0] DEV_CS    = 7'o00,
  parameter int unsigned         SETTLE    = 2,       // 1..15
  parameter logic [EBUS_DW-1:0]  PI_VECTOR = 36'o0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [EBUS_CSW-1:0] ebus_cs,
  input  logic [EBUS_FW-1:0]  ebus_func,
  input  logic                ebus_demand,
  input  logic [EBUS_DW-1:0]  ebus_data_in,
  output logic                ebus_xfer,
  output logic                ebus_driving,
  output logic [EBUS_DW-1:0]  ebus_data_out,
  output logic [EBUS_PIW-1:0] ebus_pi,
  input  logic [EBUS_DW-1:0]  dev_status,
  input  logic [EBUS_DW-1:0]  dev_datai,
  input  logic                dev_pi_req,
  output logic [EBUS_DW-1:0]  cono_q,
  output logic [EBUS_DW-1:0]  datao_q,
  output logic                cono_stb,
  output logic                datao_stb,
  output logic                datai_stb
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  tEBUSrspState state;
  tEBUSfunc     func_q;
  logic [3:0]   cnt;
  logic         sel_dev, sel_pi, serve_done;
  logic [3:0]   cnt_nxt;

  // Device functions need our select code; PI serve answers on any select
  // but only while we are actually requesting.
  assign sel_dev = ebus_demand && (ebus_cs == DEV_CS) && func_is_dev(ebus_func);
  assign sel_pi  = ebus_demand && (ebus_func == funcPISERV) && dev_pi_req &&
                   (ebus_pi != '0);

  assign serve_done = (state == rspHOLD) && !ebus_demand && (func_q == funcPISERV);
  assign cnt_nxt    = cnt + 4'd1;

  // Transfer sequencer; all bus-facing outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= rspIDLE;
      func_q        <= funcCONO;
      cnt           <= '0;
      ebus_xfer     <= 1'b0;
      ebus_driving  <= 1'b0;
      ebus_data_out <= '0;
      cono_q        <= '0;
      datao_q       <= '0;
      cono_stb      <= 1'b0;
      datao_stb     <= 1'b0;
      datai_stb     <= 1'b0;
    end else begin
      cono_stb  <= 1'b0;
      datao_stb <= 1'b0;
      datai_stb <= 1'b0;
      case (state)
        rspIDLE: begin
          if (sel_dev || sel_pi) begin
            func_q <= tEBUSfunc'(ebus_func);
            cnt    <= '0;
            state  <= rspSETTLE;
          end
        end
        rspSETTLE: begin
          if (!ebus_demand) begin
            state <= rspIDLE;  // initiator gave up before data was valid
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == SETTLE_CNT)
              state <= func_is_write(func_q) ? rspWXFER : rspRXFER;
          end
        end
        rspWXFER: begin
          if (func_q == funcCONO) begin
            cono_q   <= ebus_data_in;
            cono_stb <= 1'b1;
          end else begin
            datao_q   <= ebus_data_in;
            datao_stb <= 1'b1;
          end
          ebus_xfer <= 1'b1;
          state     <= rspHOLD;
        end
        rspRXFER: begin
          // sampled once here; HOLD keeps this word even if the source moves
          case (func_q)
            funcCONI:  ebus_data_out <= dev_status;
            funcDATAI: ebus_data_out <= dev_datai;
            default:   ebus_data_out <= PI_VECTOR;
          endcase
          datai_stb    <= (func_q == funcDATAI);
          ebus_driving <= 1'b1;
          ebus_xfer    <= 1'b1;
          state        <= rspHOLD;
        end
        rspHOLD: begin
          if (!ebus_demand) begin
            ebus_xfer     <= 1'b0;
            ebus_driving  <= 1'b0;
            ebus_data_out <= '0;
            state         <= rspIDLE;
          end
        end
        default: state <= rspIDLE;
      endcase
    end
  end

  // PI level is the low 3 bits (EBUS bits 33:35) of the last CONO word
  ebus_pi_gen u_pi_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (cono_q[EBUS_LW-1:0]),
    .dev_pi_req (dev_pi_req),
    .serve_done (serve_done),
    .ebus_pi    (ebus_pi)
  );

endmodule

// File: tb/tb_ebus_responder.sv
// Randomized bench for ebus_responder against a transaction-level model:
// expected strobes, latched words, read data and PI lines are derived from
// the select/function/level rules, not from the RTL state machine.
module tb_ebus_responder;

  localparam logic [6:0]  DEV_CS = 7'o12;
  localparam int          SETTLE = 2;
  localparam int          LAT    = SETTLE + 2;
  localparam logic [35:0] PI_VEC = 36'o765432_100017;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  ebus_cs = '0;
  logic [2:0]  ebus_func = '0;
  logic        ebus_demand = 1'b0;
  logic [35:0] ebus_data_in = '0;
  logic        ebus_xfer, ebus_driving;
  logic [35:0] ebus_data_out;
  logic [7:0]  ebus_pi;
  logic [35:0] dev_status = '0;
  logic [35:0] dev_datai = '0;
  logic        dev_pi_req = 1'b0;
  logic [35:0] cono_q, datao_q;
  logic        cono_stb, datao_stb, datai_stb;

  always #5 clk = ~clk;

  ebus_responder #(.DEV_CS(DEV_CS), .SETTLE(SETTLE), .PI_VECTOR(PI_VEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ebus_cs(ebus_cs), .ebus_func(ebus_func), .ebus_demand(ebus_demand),
    .ebus_data_in(ebus_data_in), .ebus_xfer(ebus_xfer), .ebus_driving(ebus_driving),
    .ebus_data_out(ebus_data_out), .ebus_pi(ebus_pi),
    .dev_status(dev_status), .dev_datai(dev_datai), .dev_pi_req(dev_pi_req),
    .cono_q(cono_q), .datao_q(datao_q),
    .cono_stb(cono_stb), .datao_stb(datao_stb), .datai_stb(datai_stb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %o expected %o", tag, obs, exp);
    end
  endtask

  // strobe pulse counters, cleared by the stimulus at the start of each txn
  int n_cono = 0, n_datao = 0, n_datai = 0;
  always @(posedge clk) begin
    if (cono_stb)  n_cono  <= n_cono + 1;
    if (datao_stb) n_datao <= n_datao + 1;
    if (datai_stb) n_datai <= n_datai + 1;
  end

  // reference model state
  logic [35:0] m_cono = '0;
  logic [35:0] m_datao = '0;
  bit          m_blocked = 1'b0;

  function automatic logic [7:0] m_pi();
    int lvl;
    lvl = int'(m_cono[2:0]);
    if (dev_pi_req && !m_blocked && lvl != 0) return 8'h80 >> lvl;
    return 8'h00;
  endfunction

  function automatic logic [35:0] rnd36();
    return {4'($urandom()), $urandom()};
  endfunction

  task automatic set_pi(input bit v);
    @(negedge clk);
    dev_pi_req = v;
    @(negedge clk);
    if (!v) m_blocked = 1'b0;
    chk("pi_lines", ebus_pi, m_pi());
  endtask

  // One EBUS transfer; abort_at>0 drops demand after that many clocks of SETTLE
  task automatic run_txn(input logic [6:0] cs, input logic [2:0] fn, input logic [35:0] wd,
                         input int abort_at, input int hold_extra);
    bit          sel, done;
    logic [35:0] rexp;
    sel  = (fn <= 3'd3 && cs == DEV_CS) || (fn == 3'd4 && dev_pi_req && m_pi() != 0);
    rexp = (fn == 3'd1) ? dev_status : (fn == 3'd3) ? dev_datai : PI_VEC;
    done = sel && (abort_at == 0);
    @(negedge clk);
    n_cono = 0; n_datao = 0; n_datai = 0;
    ebus_cs = cs; ebus_func = fn; ebus_data_in = wd; ebus_demand = 1'b1;
    if (!sel) begin
      repeat (20) begin
        @(negedge clk);
        chk("idle_outs", {ebus_xfer, ebus_driving, |ebus_data_out, cono_stb, datao_stb, datai_stb}, '0);
      end
      ebus_demand = 1'b0;
    end else if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      ebus_demand = 1'b0;
      repeat (LAT + 1) begin
        @(negedge clk);
        chk("abort_xfer", {ebus_xfer, ebus_driving}, '0);
      end
    end else begin
      for (int k = 1; k < LAT; k++) begin
        @(negedge clk);
        chk("pre_xfer", ebus_xfer, 1'b0);
        ebus_cs = 7'($urandom()); ebus_func = 3'($urandom());  // must be ignored now
      end
      @(negedge clk);
      chk("xfer_lat", ebus_xfer, 1'b1);
      if (fn == 3'd0) begin
        chk("cono_word", cono_q, wd); m_cono = wd;
      end else if (fn == 3'd2) begin
        chk("datao_word", datao_q, wd); m_datao = wd;
      end
      chk("driving", ebus_driving, (fn == 3'd1 || fn >= 3'd3));
      chk("rd_data", ebus_data_out, (fn == 3'd0 || fn == 3'd2) ? 36'o0 : rexp);
      dev_status = rnd36(); dev_datai = rnd36(); ebus_data_in = rnd36();
      repeat (hold_extra) begin
        @(negedge clk);
        chk("hold_xfer", ebus_xfer, 1'b1);
        chk("hold_data", ebus_data_out, (fn == 3'd0 || fn == 3'd2) ? 36'o0 : rexp);
      end
      ebus_demand = 1'b0;
      @(negedge clk);
      if (fn == 3'd4) m_blocked = 1'b1;
      chk("release", {ebus_xfer, ebus_driving, |ebus_data_out}, '0);
    end
    chk("cono_stbs",  n_cono,  (done && fn == 3'd0) ? 1 : 0);
    chk("datao_stbs", n_datao, (done && fn == 3'd2) ? 1 : 0);
    chk("datai_stbs", n_datai, (done && fn == 3'd3) ? 1 : 0);
    chk("cono_q",  cono_q,  m_cono);
    chk("datao_q", datao_q, m_datao);
    chk("pi_after", ebus_pi, m_pi());
    @(negedge clk);  // mandatory IDLE gap
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", {ebus_xfer, ebus_driving, cono_stb, datao_stb, datai_stb}, '0);
    chk("rst_data", ebus_data_out, '0);
    chk("rst_pi", ebus_pi, '0);
    chk("rst_cono", cono_q, '0);
    chk("rst_datao", datao_q, '0);
    rst_n = 1'b1;

    // CONO level 3, then PI request on line 3
    run_txn(DEV_CS, 3'd0, 36'o000000_000003, 0, 1);
    set_pi(1'b1);
    chk("pi_line3", ebus_pi, 8'b0001_0000);

    // DATAI read with hold
    dev_datai = 36'o123456_701234;
    run_txn(DEV_CS, 3'd3, 36'o0, 0, 2);

    // non-selecting demands
    run_txn(DEV_CS ^ 7'o01, 3'd0, 36'o777, 0, 0);
    run_txn(DEV_CS, 3'd5, 36'o777, 0, 0);

    // demand dropped during SETTLE
    run_txn(DEV_CS, 3'd0, 36'o707070_707070, 1, 0);
    run_txn(DEV_CS, 3'd2, 36'o525252_525252, 2, 0);

    // async reset in the HOLD of a CONI
    @(negedge clk);
    dev_status = 36'o111222_333444;
    ebus_cs = DEV_CS; ebus_func = 3'd1; ebus_demand = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("coni_xfer", ebus_xfer, 1'b1);
    chk("coni_data", ebus_data_out, 36'o111222_333444);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {ebus_xfer, ebus_driving, |ebus_data_out}, '0);
    chk("arst_cono", cono_q, '0);
    ebus_demand = 1'b0;
    m_cono = '0; m_datao = '0; m_blocked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(DEV_CS, 3'd1, 36'o0, 0, 0);

    // level 5, PI serve, line drops and stays down until a new request
    run_txn(DEV_CS, 3'd0, 36'o000000_000005, 0, 0);
    set_pi(1'b0);
    set_pi(1'b1);
    chk("pi_line5", ebus_pi, 8'b0000_0100);
    run_txn(7'o55, 3'd4, 36'o0, 0, 1);
    chk("pi_served", ebus_pi, 8'h00);
    run_txn(DEV_CS, 3'd4, 36'o0, 0, 0);  // no pending request: ignored
    set_pi(1'b0);
    set_pi(1'b1);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      logic [6:0] cs;
      logic [2:0] fn;
      int         ab;
      fn = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cs = ($urandom_range(0, 3) == 0) ? 7'($urandom()) : DEV_CS;
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, SETTLE) : 0;
      dev_status = rnd36();
      dev_datai  = rnd36();
      if ($urandom_range(0, 3) == 0) set_pi(1'($urandom()));
      run_txn(cs, fn, rnd36(), ab, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
